// File: rtl/viterbi_decoder_if.sv
// Symbol-in / bit-out stream bundle for viterbi_decoder.
//   i_sym, i_sym_valid, i_sym_last, o_sym_ready : received code symbol handshake
//   o_bit, o_bit_valid, i_bit_ready             : decoded bit handshake
//   o_done, o_overflow                          : frame status pulses
// master drives symbols and bit backpressure; slave is the decoder side.
interface viterbi_decoder_if #(
    parameter int unsigned MAX_RATE = 3
);
    logic [MAX_RATE-1:0] i_sym;
    logic                i_sym_valid;
    logic                i_sym_last;
    logic                o_sym_ready;
    logic                o_bit;
    logic                o_bit_valid;
    logic                i_bit_ready;
    logic                o_done;
    logic                o_overflow;

    modport master (
        output i_sym, i_sym_valid, i_sym_last, i_bit_ready,
        input  o_sym_ready, o_bit, o_bit_valid, o_done, o_overflow
    );

    modport slave (
        input  i_sym, i_sym_valid, i_sym_last, i_bit_ready,
        output o_sym_ready, o_bit, o_bit_valid, o_done, o_overflow
    );
endinterface

// File: rtl/viterbi_decoder.sv
// Hard-decision frame Viterbi decoder: one radix-2 ACS step per accepted
// symbol, traceback from state 0 at frame end, decoded bits streamed in order.
// Ports:
//   clk, rst      : clock, async active-low reset
//   en_vd         : block enable, low returns to IDLE with outputs cleared
//   i_code_rate   : 0 = rate 1/2, 1 = rate 1/3
//   i_constr_len  : 00 K3, 01 K5, 10 K7, 11 K9
//   i_gen_poly    : [i][k] tap of poly i on the bit k steps ago
//   vd            : symbol/bit stream interface (slave side)
module viterbi_decoder #(
    parameter int unsigned MAX_K     = 9,
    parameter int unsigned MAX_RATE  = 3,
    parameter int unsigned MAX_FRAME = 64,
    parameter int unsigned PM_W      = 10
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en_vd,
    input  logic                           i_code_rate,
    input  logic [1:0]                     i_constr_len,
    input  logic [MAX_RATE-1:0][MAX_K-1:0] i_gen_poly,
    viterbi_decoder_if.slave               vd
);
    localparam int unsigned SW = MAX_K - 1;
    localparam int unsigned NS = 1 << SW;
    localparam int unsigned AW = $clog2(MAX_FRAME);
    localparam int unsigned CW = $clog2(MAX_FRAME + 1);
    localparam int unsigned KW = $clog2(MAX_K);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACS,
        ST_TB,
        ST_OUT,
        ST_DONE
    } state_e;

    state_e                         state_q, state_d;
    logic                           rate_q, rate_d;
    logic [1:0]                     klen_q, klen_d;
    logic [MAX_RATE-1:0][MAX_K-1:0] gen_q, gen_d;
    logic [NS-1:0][PM_W-1:0]        pm_q, pm_d, pm_src, pm_acs;
    logic [NS-1:0]                  dec_acs;
    logic [NS-1:0]                  surv_q [MAX_FRAME];
    logic [CW-1:0]                  n_q, n_d, frame_n_q, frame_n_d;
    logic [AW-1:0]                  tb_stage_q, tb_stage_d, ptr_q, ptr_d;
    logic [SW-1:0]                  tb_s_q, tb_s_d;
    logic [MAX_FRAME-1:0]           dbuf_q, dbuf_d;
    logic                           sym_ready_q, sym_ready_d;
    logic                           bit_q, bit_d;
    logic                           bit_valid_q, bit_valid_d;
    logic                           done_q, done_d;
    logic                           ovf_q, ovf_d;

    logic                           rate_c;
    logic [1:0]                     klen_c;
    logic [MAX_RATE-1:0][MAX_K-1:0] gen_c;
    logic [KW-1:0]                  km1_c;
    logic                           sym_acc;
    logic                           tb_x;

    // Frame-start metrics: state 0 favoured, everything else pushed far away.
    function automatic logic [NS-1:0][PM_W-1:0] pm_init();
        logic [NS-1:0][PM_W-1:0] v;
        for (int unsigned s = 0; s < NS; s++) begin
            v[s] = (s == 0) ? '0 : (PM_W'(1) << (PM_W - 2));
        end
        return v;
    endfunction

    // Hamming distance between received symbol and the branch's expected symbol.
    function automatic logic [1:0] branch_metric(
        input logic [MAX_K-1:0]                 r,
        input logic [MAX_RATE-1:0][MAX_K-1:0]   g,
        input logic                             rate13,
        input logic [MAX_RATE-1:0]              sym
    );
        logic [1:0] d;
        d = '0;
        for (int unsigned i = 0; i < MAX_RATE; i++) begin
            if (i < 2 || rate13) begin
                d = d + 2'((^(g[i] & r)) ^ sym[i]);
            end
        end
        return d;
    endfunction

    // Config in use: live inputs on the first symbol, latched copy afterwards.
    always_comb begin
        if (state_q == ST_IDLE) begin
            rate_c = i_code_rate;
            klen_c = i_constr_len;
            gen_c  = i_gen_poly;
        end else begin
            rate_c = rate_q;
            klen_c = klen_q;
            gen_c  = gen_q;
        end
        km1_c = KW'({klen_c, 1'b0}) + KW'(2);
    end

    assign sym_acc = en_vd && sym_ready_q && vd.i_sym_valid;

    // Full-parallel add-compare-select over all active states.
    always_comb begin
        logic [SW-1:0]    s_v, p0, p1;
        logic [MAX_K-1:0] r0, r1;
        logic [PM_W-1:0]  m0, m1, diff;
        s_v     = '0;
        p0      = '0;
        p1      = '0;
        r0      = '0;
        r1      = '0;
        m0      = '0;
        m1      = '0;
        diff    = '0;
        pm_src  = (state_q == ST_IDLE) ? pm_init() : pm_q;
        pm_acs  = pm_src;
        dec_acs = '0;
        for (int unsigned s = 0; s < NS; s++) begin
            if ((s >> km1_c) == 0) begin
                s_v  = SW'(s);
                p0   = s_v >> 1;
                p1   = p0 | (SW'(1) << (km1_c - KW'(1)));
                // {p,b} equals s with the oldest bit x placed at position K-1
                r0   = MAX_K'(s_v);
                r1   = r0 | (MAX_K'(1) << km1_c);
                m0   = pm_src[p0] + PM_W'(branch_metric(r0, gen_c, rate_c, vd.i_sym));
                m1   = pm_src[p1] + PM_W'(branch_metric(r1, gen_c, rate_c, vd.i_sym));
                // modulo compare: m1 < m0 when the difference is negative
                diff = m1 - m0;
                if (diff[PM_W-1]) begin
                    pm_acs[s]  = m1;
                    dec_acs[s] = 1'b1;
                end else begin
                    pm_acs[s]  = m0;
                end
            end
        end
    end

    // Survivor decisions, one row per accepted symbol.
    always_ff @(posedge clk) begin
        if (sym_acc) begin
            surv_q[n_q[AW-1:0]] <= dec_acs;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        rate_d     = rate_q;
        klen_d     = klen_q;
        gen_d      = gen_q;
        pm_d       = pm_q;
        n_d        = n_q;
        frame_n_d  = frame_n_q;
        tb_stage_d = tb_stage_q;
        tb_s_d     = tb_s_q;
        ptr_d      = ptr_q;
        dbuf_d     = dbuf_q;
        ovf_d      = 1'b0;
        tb_x       = surv_q[tb_stage_q][tb_s_q];

        unique case (state_q)
            ST_IDLE, ST_ACS: begin
                if (sym_acc) begin
                    pm_d = pm_acs;
                    n_d  = n_q + CW'(1);
                    if (state_q == ST_IDLE) begin
                        rate_d  = i_code_rate;
                        klen_d  = i_constr_len;
                        gen_d   = i_gen_poly;
                        state_d = ST_ACS;
                    end
                    if (vd.i_sym_last || n_q == CW'(MAX_FRAME - 1)) begin
                        state_d    = ST_TB;
                        tb_stage_d = AW'(n_q);
                        frame_n_d  = n_q + CW'(1);
                        tb_s_d     = '0;
                        ovf_d      = !vd.i_sym_last;
                    end
                end
            end
            ST_TB: begin
                // tail stages (last K-1) are traced but not kept
                if ((CW'(tb_stage_q) + CW'(km1_c)) < frame_n_q) begin
                    dbuf_d[tb_stage_q] = tb_s_q[0];
                end
                tb_s_d = (tb_s_q >> 1) | (SW'(tb_x) << (km1_c - KW'(1)));
                if (tb_stage_q == '0) begin
                    state_d = (frame_n_q <= CW'(km1_c)) ? ST_DONE : ST_OUT;
                    ptr_d   = '0;
                end else begin
                    tb_stage_d = tb_stage_q - AW'(1);
                end
            end
            ST_OUT: begin
                if (bit_valid_q && vd.i_bit_ready) begin
                    if ((CW'(ptr_q) + CW'(km1_c) + CW'(1)) == frame_n_q) begin
                        state_d = ST_DONE;
                    end else begin
                        ptr_d = ptr_q + AW'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                n_d     = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!en_vd) begin
            state_d    = ST_IDLE;
            n_d        = '0;
            frame_n_d  = '0;
            tb_stage_d = '0;
            tb_s_d     = '0;
            ptr_d      = '0;
            ovf_d      = 1'b0;
        end

        // outputs are registered from the next state so they align with it
        sym_ready_d = en_vd && (state_d == ST_IDLE || state_d == ST_ACS);
        bit_valid_d = (state_d == ST_OUT);
        bit_d       = (state_d == ST_OUT) ? dbuf_d[ptr_d] : 1'b0;
        done_d      = (state_d == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            rate_q      <= 1'b0;
            klen_q      <= '0;
            gen_q       <= '0;
            pm_q        <= pm_init();
            n_q         <= '0;
            frame_n_q   <= '0;
            tb_stage_q  <= '0;
            tb_s_q      <= '0;
            ptr_q       <= '0;
            dbuf_q      <= '0;
            sym_ready_q <= 1'b0;
            bit_q       <= 1'b0;
            bit_valid_q <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rate_q      <= rate_d;
            klen_q      <= klen_d;
            gen_q       <= gen_d;
            pm_q        <= pm_d;
            n_q         <= n_d;
            frame_n_q   <= frame_n_d;
            tb_stage_q  <= tb_stage_d;
            tb_s_q      <= tb_s_d;
            ptr_q       <= ptr_d;
            dbuf_q      <= dbuf_d;
            sym_ready_q <= sym_ready_d;
            bit_q       <= bit_d;
            bit_valid_q <= bit_valid_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
        end
    end

    assign vd.o_sym_ready = sym_ready_q;
    assign vd.o_bit       = bit_q;
    assign vd.o_bit_valid = bit_valid_q;
    assign vd.o_done      = done_q;
    assign vd.o_overflow  = ovf_q;
endmodule

// File: doc/viterbi_decoder.md
# viterbi_decoder

Hard-decision, frame-based Viterbi decoder that inverts the team's convolutional encoder. It uses the same code-rate, constraint-length and generator-polynomial encoding, so one configuration drives both ends of the link. It accepts one received code symbol per cycle and runs one full-parallel radix-2 ACS trellis step per symbol. At frame end it traces back from state 0, since frames are zero-tail terminated, and streams decoded bits in forward order.

## Interface
- `MAX_K`, 9: max constraint length; state register width is `MAX_K-1`.
- `MAX_RATE`, 3: max code symbols per bit.
- `MAX_FRAME`, 64: max symbols per frame, tail included.
- `PM_W`, 10: path-metric width in bits.
- Reset and clock: reset `rst`, asynchronous, active-low; clock `clk`.
- `clk`  in  1  clock.
- `rst`  in  1  async active-low reset.
- `en_vd`  in  1  block enable; low forces IDLE.
- `i_code_rate`  in  1  0 = rate 1/2, 1 = rate 1/3.
- `i_constr_len`  in  2  00 = K3, 01 = K5, 10 = K7, 11 = K9.
- `i_gen_poly`  in  `MAX_K` x `MAX_RATE`  taps; `[i][k]` taps the bit input k steps ago (k=0 is the newest).
- `i_sym`  in  `MAX_RATE`  received symbol; bit i is the output of poly i.
- `i_sym_valid`  in  1  symbol valid.
- `i_sym_last`  in  1  last symbol of the frame.
- `o_sym_ready`  out  1  decoder accepts a symbol.
- `o_bit`  out  1  decoded bit.
- `o_bit_valid`  out  1  decoded bit valid.
- `i_bit_ready`  in  1  downstream accepts a bit.
- `o_done`  out  1  one-cycle pulse after the frame's last bit.
- `o_overflow`  out  1  one-cycle pulse when the frame is truncated at `MAX_FRAME`.

## Operation
- Configuration (`i_code_rate`, `i_constr_len`, `i_gen_poly`) is sampled on the first accepted symbol of a frame and held until `o_done`.
- **State numbering**
  - s = last K-1 input bits, newest in bit 0.
  - Predecessors of s: p = (s>>1) | (x<<(K-2)), x ∈ {0,1}; input bit b = s[0].
  - Expected branch symbol: bit i = XOR over k of `gen_poly[i][k]` & {p,b}[k].
- **Branch metric**: Hamming distance over bits 0..1 (rate 1/2) or 0..2 (rate 1/3). `i_sym[2]` is ignored at rate 1/2.
- **ACS**
  - New PM(s) = min over x of PM(p_x) + BM.
  - Ties pick x=0.
  - The decision bit x is stored in survivor memory `[stage][s]`.
  - States ≥ 2^(K-1) are unused and held.
- **Path metrics**
  - Modulo arithmetic, no normalisation.
  - Compare a<b as MSB of (a−b) set.
  - Initial values at frame start: PM(0)=0, all others 2^(PM_W−2).
- **FSM**
  - IDLE → ACS on the first accepted symbol.
  - ACS → TB on accepting `i_sym_last`, or on the `MAX_FRAME`-th symbol (also pulses `o_overflow`).
  - TB → OUT after stage 0; TB → DONE directly if N ≤ K−1.
  - OUT → DONE after the last bit handshake.
  - DONE → IDLE after one cycle, with `o_done`=1 in that cycle.
- **Traceback**
  - Starts at state 0, stage N−1, one stage per cycle.
  - At each stage: decoded bit = s[0], then s ← (s>>1) | (x<<(K-2)).
  - Bits of stages < N−(K−1) are written into a decode buffer; tail bits are discarded.
- **Output**
  - OUT streams buffer bits 0..N−K in forward order.
  - The pointer advances only when `o_bit_valid` & `i_bit_ready`.
  - `o_bit` and `o_bit_valid` hold while `i_bit_ready`=0.
- `o_sym_ready` = 1 only in IDLE and ACS.
- `en_vd`=0 in any state: next cycle is IDLE, counters are cleared, and all outputs are 0. Buffer contents are don't-care.

## Timing
- All outputs reset to 0. FSM resets to IDLE; PMs reset to the initial values.
- ACS takes 1 cycle per symbol, so full throughput is 1 symbol/cycle with `i_sym_valid` held.
- After the last-symbol accept at cycle t, TB occupies cycles t+1..t+N.
- First `o_bit_valid` is at t+N+1.
- With `i_bit_ready`=1, `o_done` is at t+N+1+(N−K+1).
- If N ≤ K−1, `o_done` is at t+N+1 and no bits are emitted.
- `o_overflow` is coincident with the cycle after the `MAX_FRAME`-th accept.
- If `i_sym_valid` and `i_sym_last` arrive on a frame's first symbol (N=1), the block goes straight to TB.

## Test plan
- K3, rate 1/2, `gen_poly[0]`=9'b000000111, `gen_poly[1]`=9'b000000101; symbols 011,001,000,010,010,011 with last on the 6th → `o_bit` 1,0,1,1 on consecutive cycles from t+7, then `o_done` at t+11.
- Same frame, but the 3rd symbol is 001 and the 2nd is 101 (a single real error, plus an ignored bit 2) → still 1,0,1,1.
- K9, rate 1/3, polys 9'o557/9'o663/9'o711; 50 random bits plus 8 zero tail bits from a reference encoder, with 2 bit errors 20 stages apart → all 50 bits exact.
- Backpressure: `i_bit_ready` toggling 0/1 every cycle during OUT → every bit delivered once, in order, stable while stalled.
- `rst` low, and separately `en_vd` low, mid-TB → outputs 0 and IDLE next cycle; the following frame from test 1 decodes correctly.
- K3, N=2 → no `o_bit_valid`, `o_done` at t+3. A 70-symbol stream without last → `o_overflow` after the 64th symbol, `o_sym_ready`=0, and 62 bits output.
